// File: rtl/jtframe_ddram_avl.sv
// Registered bridge from the frame buffer's MiSTer-style DDRAM port to the DECA UniPHY
// Avalon-MM local port, with read-beat credit tracking and a calibration gate.
module jtframe_ddram_avl #(
  parameter int AW    = 26,
  parameter int BW    = 8,
  parameter int MAXRD = 16,
  parameter int BASE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cal_done,
  input  logic [28:0]   ddram_addr,
  input  logic [BW-1:0] ddram_burstcnt,
  input  logic          ddram_rd,
  input  logic          ddram_we,
  input  logic [63:0]   ddram_din,
  input  logic [7:0]    ddram_be,
  output logic          ddram_busy,
  output logic [63:0]   ddram_dout,
  output logic          ddram_dout_ready,
  input  logic          avl_ready,
  output logic [AW-1:0] avl_addr,
  output logic [BW-1:0] avl_size,
  output logic          avl_burstbegin,
  output logic          avl_read_req,
  output logic          avl_write_req,
  output logic [63:0]   avl_wdata,
  output logic [7:0]    avl_be,
  input  logic [63:0]   avl_rdata,
  input  logic          avl_rdata_valid,
  output logic          err
);
  localparam int CW = $clog2(MAXRD + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          cal_q, cal_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] size_q, size_d;
  logic [BW-1:0] beats_left_q, beats_left_d;
  logic          burstbegin_q, burstbegin_d;
  logic          read_req_q, read_req_d;
  logic          write_req_q, write_req_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [63:0]   dout_q, dout_d;
  logic          dout_ready_q, dout_ready_d;
  logic          err_q, err_d;

  logic [BW-1:0] eff_cnt;
  logic [31:0]   credit_need;
  logic          rd_credit;
  logic          busy;
  logic [BW-1:0] inc;
  logic          dec;
  logic          unused_addr;

  assign unused_addr = ^ddram_addr[28:AW];

  // A zero burst count still moves one beat, so it is charged as one.
  assign eff_cnt     = (ddram_burstcnt == '0) ? BW'(1) : ddram_burstcnt;
  assign credit_need = 32'(outstanding_q) + 32'(eff_cnt);
  assign rd_credit   = credit_need <= 32'(MAXRD);
  assign busy        = (state_q == RD) || (state_q == WR) ||
                       ((state_q == IDLE) && (!cal_q || !rd_credit));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    beats_left_d = beats_left_q;
    burstbegin_d = burstbegin_q;
    read_req_d   = read_req_q;
    write_req_d  = write_req_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    err_d        = err_q;
    cal_d        = cal_done;
    dout_d       = avl_rdata;
    dout_ready_d = avl_rdata_valid;
    inc          = '0;
    case (state_q)
      IDLE: begin
        if (!busy && ddram_we) begin
          addr_d       = ddram_addr[AW-1:0] + AW'(BASE);
          size_d       = eff_cnt;
          beats_left_d = eff_cnt - BW'(1);
          wdata_d      = ddram_din;
          be_d         = ddram_be;
          write_req_d  = 1'b1;
          burstbegin_d = 1'b1;
          state_d      = WR;
          if (ddram_rd) err_d = 1'b1;
        end else if (!busy && ddram_rd) begin
          addr_d       = ddram_addr[AW-1:0] + AW'(BASE);
          size_d       = eff_cnt;
          read_req_d   = 1'b1;
          burstbegin_d = 1'b1;
          state_d      = RD;
        end
      end
      RD: begin
        burstbegin_d = 1'b0;
        if (avl_ready) begin
          read_req_d = 1'b0;
          inc        = size_q;
          state_d    = IDLE;
        end
      end
      WR: begin
        burstbegin_d = 1'b0;
        if (avl_ready) begin
          write_req_d = 1'b0;
          state_d     = (beats_left_q == '0) ? IDLE : WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (ddram_rd) err_d = 1'b1;
        if (ddram_we) begin
          wdata_d      = ddram_din;
          be_d         = ddram_be;
          beats_left_d = beats_left_q - BW'(1);
          write_req_d  = 1'b1;
          state_d      = WR;
        end
      end
      default: state_d = IDLE;
    endcase
    // Returned data with nothing outstanding is a protocol error and is not counted.
    dec = avl_rdata_valid && (outstanding_q != '0);
    if (avl_rdata_valid && (outstanding_q == '0)) err_d = 1'b1;
    outstanding_d = outstanding_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      cal_q         <= 1'b0;
      addr_q        <= '0;
      size_q        <= '0;
      beats_left_q  <= '0;
      burstbegin_q  <= 1'b0;
      read_req_q    <= 1'b0;
      write_req_q   <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      dout_q        <= '0;
      dout_ready_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      cal_q         <= cal_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      beats_left_q  <= beats_left_d;
      burstbegin_q  <= burstbegin_d;
      read_req_q    <= read_req_d;
      write_req_q   <= write_req_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      dout_q        <= dout_d;
      dout_ready_q  <= dout_ready_d;
      err_q         <= err_d;
    end
  end

  assign ddram_busy       = busy;
  assign ddram_dout       = dout_q;
  assign ddram_dout_ready = dout_ready_q;
  assign avl_addr         = addr_q;
  assign avl_size         = size_q;
  assign avl_burstbegin   = burstbegin_q;
  assign avl_read_req     = read_req_q;
  assign avl_write_req    = write_req_q;
  assign avl_wdata        = wdata_q;
  assign avl_be           = be_q;
  assign err              = err_q;

endmodule

// File: tb/tb_jtframe_ddram_avl.sv
// Directed bench for jtframe_ddram_avl: calibration gate, reads, credit limit,
// write bursts, error paths and reset mid-read, with queued expected data.
module tb_jtframe_ddram_avl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cal_done;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt;
  logic        ddram_rd, ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        avl_ready;
  logic [25:0] avl_addr;
  logic [7:0]  avl_size;
  logic        avl_burstbegin, avl_read_req, avl_write_req;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic [63:0] avl_rdata;
  logic        avl_rdata_valid;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [63:0] rq[$];
  logic [63:0] wq[$];

  jtframe_ddram_avl #(.AW(26), .BW(8), .MAXRD(16), .BASE(32'h100)) dut (
    .clk(clk), .rst(rst), .cal_done(cal_done),
    .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_busy(ddram_busy), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    logic [63:0] e;
    avl_rdata = d;
    avl_rdata_valid = 1'b1;
    rq.push_back(d);
    tick();
    e = (rq.size() > 0) ? rq.pop_front() : 64'hDEAD;
    chk("dout_ready", 64'(ddram_dout_ready), 64'd1);
    chk("dout", ddram_dout, e);
  endtask

  task automatic wcheck(input string tag, input logic bb);
    logic [63:0] e;
    e = (wq.size() > 0) ? wq.pop_front() : 64'hDEAD;
    chk({tag, "_req"}, 64'(avl_write_req), 64'd1);
    chk({tag, "_bb"}, 64'(avl_burstbegin), 64'(bb));
    chk({tag, "_wdata"}, avl_wdata, e);
    chk({tag, "_busy"}, 64'(ddram_busy), 64'd1);
  endtask

  task automatic do_read(input logic [28:0] a, input logic [7:0] n);
    ddram_addr = a;
    ddram_burstcnt = n;
    ddram_rd = 1'b1;
    #1;
    chk("rd_not_busy", 64'(ddram_busy), 64'd0);
    tick();
    ddram_rd = 1'b0;
    avl_ready = 1'b1;
    tick();
    avl_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cal_done = 1'b0; ddram_addr = '0; ddram_burstcnt = '0;
    ddram_rd = 1'b0; ddram_we = 1'b0; ddram_din = '0; ddram_be = '0;
    avl_ready = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(ddram_busy), 64'd1);
    chk("rst_rdreq", 64'(avl_read_req), 64'd0);
    chk("rst_wrreq", 64'(avl_write_req), 64'd0);
    chk("rst_dready", 64'(ddram_dout_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(avl_addr), 64'd0);
    rst = 1'b0;

    // calibration gate
    ddram_addr = 29'h5; ddram_burstcnt = 8'd1; ddram_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cal_busy", 64'(ddram_busy), 64'd1);
      chk("cal_noreq", 64'(avl_read_req), 64'd0);
    end
    ddram_rd = 1'b0;
    cal_done = 1'b1;
    tick();
    chk("cal_busy_drop", 64'(ddram_busy), 64'd0);

    // single read with delayed ready
    ddram_addr = 29'h10; ddram_burstcnt = 8'd4; ddram_rd = 1'b1;
    tick();
    ddram_rd = 1'b0;
    chk("rd_req1", 64'(avl_read_req), 64'd1);
    chk("rd_bb1", 64'(avl_burstbegin), 64'd1);
    chk("rd_addr", 64'(avl_addr), 64'h110);
    chk("rd_size", 64'(avl_size), 64'd4);
    chk("rd_busy", 64'(ddram_busy), 64'd1);
    tick();
    chk("rd_req2", 64'(avl_read_req), 64'd1);
    chk("rd_bb2", 64'(avl_burstbegin), 64'd0);
    tick();
    chk("rd_req3", 64'(avl_read_req), 64'd1);
    avl_ready = 1'b1;
    tick();
    avl_ready = 1'b0;
    chk("rd_done_req", 64'(avl_read_req), 64'd0);
    chk("rd_done_busy", 64'(ddram_busy), 64'd0);
    chk("rd_outst4", 64'(dut.outstanding_q), 64'd4);
    for (int i = 0; i < 4; i++) beat(64'hD000 + 64'(i));
    avl_rdata_valid = 1'b0;
    tick();
    chk("rd_dready_off", 64'(ddram_dout_ready), 64'd0);
    chk("rd_outst0", 64'(dut.outstanding_q), 64'd0);

    // credit limit
    do_read(29'h20, 8'd8);
    do_read(29'h28, 8'd8);
    chk("cr_outst16", 64'(dut.outstanding_q), 64'd16);
    ddram_addr = 29'h30; ddram_burstcnt = 8'd8; ddram_rd = 1'b1;
    #1;
    chk("cr_blocked", 64'(ddram_busy), 64'd1);
    tick();
    chk("cr_noreq", 64'(avl_read_req), 64'd0);
    beat(64'hC100);
    chk("cr_still_busy", 64'(ddram_busy), 64'd1);
    chk("cr_outst15", 64'(dut.outstanding_q), 64'd15);
    chk("cr_noreq2", 64'(avl_read_req), 64'd0);
    for (int i = 0; i < 7; i++) beat(64'hC200 + 64'(i));
    avl_rdata_valid = 1'b0;
    #1;
    chk("cr_free", 64'(ddram_busy), 64'd0);
    tick();
    ddram_rd = 1'b0;
    chk("cr_accept", 64'(avl_read_req), 64'd1);
    chk("cr_outst8", 64'(dut.outstanding_q), 64'd8);
    avl_ready = 1'b1;
    beat(64'hC300);
    avl_ready = 1'b0;
    avl_rdata_valid = 1'b0;
    chk("cr_net", 64'(dut.outstanding_q), 64'd15);
    for (int i = 0; i < 15; i++) beat(64'hC400 + 64'(i));
    avl_rdata_valid = 1'b0;
    tick();
    chk("cr_drained", 64'(dut.outstanding_q), 64'd0);

    // write burst A,B,C with ready always high
    avl_ready = 1'b1;
    ddram_addr = 29'h40; ddram_burstcnt = 8'd3; ddram_we = 1'b1;
    ddram_din = 64'hAAAA_0001; ddram_be = 8'hFF; wq.push_back(ddram_din);
    tick();
    ddram_we = 1'b0;
    wcheck("wrA", 1'b1);
    chk("wr_size", 64'(avl_size), 64'd3);
    chk("wr_addr", 64'(avl_addr), 64'h140);
    tick();
    chk("wwait1_busy", 64'(ddram_busy), 64'd0);
    chk("wwait1_req", 64'(avl_write_req), 64'd0);
    ddram_we = 1'b1; ddram_din = 64'hBBBB_0002; ddram_be = 8'h0F; wq.push_back(ddram_din);
    tick();
    ddram_we = 1'b0;
    wcheck("wrB", 1'b0);
    chk("wrB_be", 64'(avl_be), 64'h0F);
    tick();
    chk("wwait2_busy", 64'(ddram_busy), 64'd0);
    chk("wwait2_req", 64'(avl_write_req), 64'd0);
    ddram_we = 1'b1; ddram_din = 64'hCCCC_0003; ddram_be = 8'hF0; wq.push_back(ddram_din);
    tick();
    ddram_we = 1'b0;
    wcheck("wrC", 1'b0);
    tick();
    chk("wr_end_req", 64'(avl_write_req), 64'd0);
    chk("wr_end_idle", 64'(dut.state_q), 64'd0);
    chk("wr_end_busy", 64'(ddram_busy), 64'd0);
    chk("wr_no_err", 64'(err), 64'd0);

    // rd and we together
    ddram_addr = 29'h50; ddram_burstcnt = 8'd1; ddram_rd = 1'b1; ddram_we = 1'b1;
    ddram_din = 64'hEEEE_0005; ddram_be = 8'hFF; wq.push_back(ddram_din);
    tick();
    ddram_rd = 1'b0; ddram_we = 1'b0;
    wcheck("both", 1'b1);
    chk("both_noread", 64'(avl_read_req), 64'd0);
    chk("both_err", 64'(err), 64'd1);
    tick();
    chk("both_done", 64'(avl_write_req), 64'd0);
    avl_ready = 1'b0;

    // unexpected read data
    beat(64'h5A5A);
    avl_rdata_valid = 1'b0;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_outst", 64'(dut.outstanding_q), 64'd0);

    // reset while a read is pending
    do_read(29'h60, 8'd2);
    chk("rr_outst2", 64'(dut.outstanding_q), 64'd2);
    ddram_addr = 29'h70; ddram_burstcnt = 8'd1; ddram_rd = 1'b1;
    tick();
    ddram_rd = 1'b0;
    chk("rr_pending", 64'(avl_read_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_req", 64'(avl_read_req), 64'd0);
    chk("rr_busy", 64'(ddram_busy), 64'd1);
    chk("rr_outst", 64'(dut.outstanding_q), 64'd0);
    chk("rr_err_clr", 64'(err), 64'd0);
    tick();
    beat(64'h7777);
    avl_rdata_valid = 1'b0;
    chk("rr_late_err", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtframe_ddram_avl.md
# jtframe_ddram_avl

Bridge between the line-frame buffer's MiSTer-style DDRAM port and the Avalon-MM port of the DECA DDR3 UniPHY controller (64-bit half-rate local interface). It registers every request and enforces UniPHY's `avl_ready`/`avl_burstbegin` protocol. It limits outstanding read beats so that returned data can always be consumed, and holds the frame buffer off until memory calibration completes. Sits directly downstream of `jtframe_lfbuf_ddr_deca`, in the `clk_rom` domain.

## Interface

Parameters:
- `AW`, 26: Avalon word address width (64-bit words).
- `BW`, 8: burst count width.
- `MAXRD`, 16: maximum outstanding read beats.
- `BASE`, 0: word offset added to every address.

Ports:
- `clk` in 1: single clock, the Avalon `afi` clock.
- `rst` in 1: reset, synchronous, active-high.
- `cal_done` in 1: `local_cal_success` from the controller.
- `ddram_addr` in 29: word address.
- `ddram_burstcnt` in BW: beats in the burst.
- `ddram_rd` in 1: read request.
- `ddram_we` in 1: write beat.
- `ddram_din` in 64: write data.
- `ddram_be` in 8: byte enables.
- `ddram_busy` out 1: stall; no request is accepted while high.
- `ddram_dout` out 64: read data.
- `ddram_dout_ready` out 1: read data valid strobe.
- `avl_ready` in 1: controller accepts the presented request or beat.
- `avl_addr` out AW.
- `avl_size` out BW.
- `avl_burstbegin` out 1.
- `avl_read_req` out 1.
- `avl_write_req` out 1.
- `avl_wdata` out 64.
- `avl_be` out 8.
- `avl_rdata` in 64.
- `avl_rdata_valid` in 1.
- `err` out 1: sticky protocol error.

## Operation

- **State machine.** States are IDLE, RD, WR, WR_WAIT.
- **IDLE.**
  - `ddram_busy = ~cal_done | ~rd_credit`, where `rd_credit = (outstanding + max(burstcnt,1) <= MAXRD)`.
  - Requests are accepted only when `ddram_busy` is 0.
  - Burst count 0 is treated as 1.
- **Accept.**
  - The bridge registers `avl_addr = (ddram_addr[AW-1:0] + BASE) mod 2^AW` and `avl_size` = burst count.
  - On `ddram_we` it also registers `wdata`/`be`, sets `beats_left = size-1` and goes to WR.
  - Otherwise, on `ddram_rd` it goes to RD.
  - If `rd` and `we` are both high, the write wins, the read is dropped and `err` is set.
- **RD.**
  - `avl_read_req = 1`; `avl_burstbegin = 1` only in the first cycle of RD.
  - `ddram_busy = 1`.
  - On `avl_ready`, `outstanding += avl_size` and the state returns to IDLE.
- **WR.**
  - `avl_write_req = 1`; `avl_burstbegin = 1` only in the first cycle of the burst's first beat.
  - `ddram_busy = 1`.
  - On `avl_ready`: if `beats_left == 0` go to IDLE, else go to WR_WAIT.
- **WR_WAIT.**
  - `ddram_busy = 0` and `avl_write_req = 0`.
  - On `ddram_we`, capture `din`/`be`, decrement `beats_left` and go to WR.
  - `ddram_rd` here sets `err` and is ignored.
- **Read return.**
  - `ddram_dout <= avl_rdata` and `ddram_dout_ready <= avl_rdata_valid` every cycle.
  - Each `avl_rdata_valid` decrements `outstanding`.
  - If an increment and a decrement land in the same cycle, the net change is applied.
  - `avl_rdata_valid` with `outstanding == 0` sets `err` and leaves `outstanding` at 0.
- **Counter width.** `outstanding` is `$clog2(MAXRD+1)` bits; it cannot exceed MAXRD by construction.
- **Calibration loss.** A fall of `cal_done` mid-transfer does not abort the current request; new accepts are blocked.
- **`err`.** Cleared only by `rst`.

## Timing

- **Reset values.** Every output is 0 except `ddram_busy = 1`. State is IDLE, `outstanding` is 0, `err` is 0.
- **Request latency.** Accept in cycle N puts `avl_*_req` high in N+1. `ddram_busy` rises in N+1 and falls in the cycle after `avl_ready` is sampled high.
- **Request hold.** Request and data are held stable while `avl_ready` is 0.
- **Minimum timing.**
  - Read: accept to next accept takes 2 cycles.
  - Write: 2 cycles per beat.
- **Read data latency.** Bridge latency is exactly 1 cycle from `avl_rdata_valid` to `ddram_dout_ready`. There is no backpressure on read data.
- **Reset mid-burst.** Outputs return to reset values in the next cycle and pending reads are forgotten. Data still arriving after reset sets `err`.

## Test plan

1. **Calibration gate.** Hold `cal_done = 0` while pulsing `ddram_rd` -> `ddram_busy` stays 1 and no `avl_read_req` is issued. Raise `cal_done` -> `busy` drops in the next cycle.
2. **Single read.** Read addr 0x10, burstcnt 4, `BASE = 0x100`, `avl_ready` delayed 3 cycles. Expect:
   - `avl_addr = 0x110` and `avl_size = 4`.
   - `burstbegin` high for 1 cycle only, `read_req` held 3 cycles.
   - 4 `rdata_valid` beats -> 4 `dout_ready` pulses, each 1 cycle later with matching data.
   - `outstanding` returns to 0.
3. **Credit limit.** `MAXRD = 16`: issue reads of burstcnt 8, 8, 8 with no data returned -> third read is blocked with `busy = 1`. Return one beat -> still blocked. Return 8 beats -> third read is accepted.
4. **Write burst.** Burst of 3 beats, data A, B, C, `avl_ready` always 1. Expect:
   - 3 `write_req` cycles with `wdata` A, B, C.
   - `burstbegin` only on A, `avl_size = 3`.
   - `busy` low in each WR_WAIT; state is IDLE after C.
5. **Error paths.**
   - `rd` and `we` together -> write performed, `err = 1`.
   - `rdata_valid` with `outstanding = 0` -> `err` stays 1 and `outstanding` stays 0.
6. **Reset mid-read.** Assert `rst` while `read_req` is pending -> next cycle `read_req = 0`, `busy = 1`, `outstanding = 0`.
